// File: rtl/mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the datapath/memory side.
// The sequencer uses the slave modport; whoever drives instructions and memory uses master.
interface mc_ctrl_if;
   logic [31:0] instr;
   logic        mem_ready;
   logic        branch_taken;
   logic        stall;
   logic [2:0]  state;
   logic        ir_write;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  alu_op;
   logic        alu_src_a;
   logic        alu_src_b;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        halted;
   logic [1:0]  halt_cause;

   modport slave (
      input  instr, mem_ready, branch_taken, stall,
      output state, ir_write, mem_req, mem_we, alu_op, alu_src_a, alu_src_b,
             reg_write, wb_sel, pc_write, pc_src, halted, halt_cause
   );

   modport master (
      output instr, mem_ready, branch_taken, stall,
      input  state, ir_write, mem_req, mem_we, alu_op, alu_src_a, alu_src_b,
             reg_write, wb_sel, pc_write, pc_src, halted, halt_cause
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: one ALU and one memory port shared across the
// FETCH/DECODE/EXEC/MEM/WB phases of each instruction.
//
//  state  | meaning
//  FETCH  | request instruction word, load IR on mem_ready
//  DECODE | classify opcode; SYSTEM or unknown opcodes halt
//  EXEC   | ALU op for the instruction; branches/fences retire here
//  MEM    | load/store data access; stores retire here
//  WB     | register write and PC update
//  HALT   | sticky stop until reset, cause held in halt_cause
module mc_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic     clk,
   input  logic     rst,
   mc_ctrl_if.slave bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int unsigned   CW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] WAIT_TC    = CW'(MEM_TIMEOUT - 1);
   localparam bit            TIMEOUT_EN = (MEM_TIMEOUT != 0);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic [1:0]    cause_q, cause_d;

   logic [6:0] opc;
   logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
   logic       is_opimm, is_op, is_fence, is_system, is_legal;
   logic       unused_instr;

   assign opc          = bus.instr[6:0];
   assign unused_instr = ^bus.instr[31:7];

   assign is_lui    = (opc == OPC_LUI);
   assign is_auipc  = (opc == OPC_AUIPC);
   assign is_jal    = (opc == OPC_JAL);
   assign is_jalr   = (opc == OPC_JALR);
   assign is_branch = (opc == OPC_BRANCH);
   assign is_load   = (opc == OPC_LOAD);
   assign is_store  = (opc == OPC_STORE);
   assign is_opimm  = (opc == OPC_OPIMM);
   assign is_op     = (opc == OPC_OP);
   assign is_fence  = (opc == OPC_FENCE);
   assign is_system = (opc == OPC_SYSTEM);
   assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                      is_store | is_opimm | is_op | is_fence | is_system;

   // ALU setup chosen in EXEC and held through MEM/WB so the address/result stays stable
   logic [1:0] exec_alu_op;
   logic       exec_src_a, exec_src_b;

   always_comb begin
      exec_alu_op = 2'b00;
      exec_src_a  = 1'b0;
      exec_src_b  = 1'b0;
      if (is_op) begin
         exec_alu_op = 2'b11;
      end else if (is_opimm) begin
         exec_alu_op = 2'b11;
         exec_src_b  = 1'b1;
      end else if (is_load | is_store | is_jalr) begin
         exec_alu_op = 2'b10;
         exec_src_b  = 1'b1;
      end else if (is_branch) begin
         exec_alu_op = 2'b01;
      end else if (is_auipc) begin
         exec_alu_op = 2'b10;
         exec_src_a  = 1'b1;
         exec_src_b  = 1'b1;
      end
   end

   logic       ir_write_c, mem_req_c, mem_we_c, reg_write_c, pc_write_c;
   logic       src_a_c, src_b_c;
   logic [1:0] alu_op_c, wb_sel_c, pc_src_c;
   logic       wait_expired;

   assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_TC);

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      cause_d     = cause_q;
      ir_write_c  = 1'b0;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      reg_write_c = 1'b0;
      pc_write_c  = 1'b0;
      src_a_c     = 1'b0;
      src_b_c     = 1'b0;
      alu_op_c    = 2'b00;
      wb_sel_c    = 2'b00;
      pc_src_c    = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (bus.mem_ready) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_HALT;
               cause_d = 2'b11;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         S_DECODE: begin
            if (is_system) begin
               state_d = S_HALT;
               cause_d = 2'b01;
            end else if (!is_legal) begin
               state_d = S_HALT;
               cause_d = 2'b10;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op_c = exec_alu_op;
            src_a_c  = exec_src_a;
            src_b_c  = exec_src_b;
            if (is_branch) begin
               pc_write_c = 1'b1;
               pc_src_c   = bus.branch_taken ? 2'b01 : 2'b00;
               state_d    = S_FETCH;
            end else if (is_fence) begin
               // single-port in-order core: FENCE has nothing to order, retire as PC+4
               pc_write_c = 1'b1;
               state_d    = S_FETCH;
            end else if (is_load | is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            alu_op_c  = exec_alu_op;
            src_a_c   = exec_src_a;
            src_b_c   = exec_src_b;
            mem_req_c = 1'b1;
            mem_we_c  = is_store;
            if (bus.mem_ready) begin
               if (is_store) begin
                  pc_write_c = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_expired) begin
               state_d = S_HALT;
               cause_d = 2'b11;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         S_WB: begin
            alu_op_c    = exec_alu_op;
            src_a_c     = exec_src_a;
            src_b_c     = exec_src_b;
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            if (is_load)                wb_sel_c = 2'b01;
            else if (is_jal | is_jalr)  wb_sel_c = 2'b10;
            else if (is_lui)            wb_sel_c = 2'b11;
            if (is_jal)                 pc_src_c = 2'b01;
            else if (is_jalr)           pc_src_c = 2'b10;
            state_d = S_FETCH;
         end
         S_HALT: begin
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (state_d != state_q) wait_d = '0;

      // request lines stay up during a stall; only the commit strobes are masked
      if (bus.stall) begin
         state_d     = state_q;
         wait_d      = wait_q;
         cause_d     = cause_q;
         ir_write_c  = 1'b0;
         reg_write_c = 1'b0;
         pc_write_c  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.ir_write   = ir_write_c  & ~rst;
   assign bus.mem_req    = mem_req_c   & ~rst;
   assign bus.mem_we     = mem_we_c    & ~rst;
   assign bus.reg_write  = reg_write_c & ~rst;
   assign bus.pc_write   = pc_write_c  & ~rst;
   assign bus.alu_src_a  = src_a_c     & ~rst;
   assign bus.alu_src_b  = src_b_c     & ~rst;
   assign bus.alu_op     = rst ? 2'b00 : alu_op_c;
   assign bus.wb_sel     = rst ? 2'b00 : wb_sel_c;
   assign bus.pc_src     = rst ? 2'b00 : pc_src_c;
   assign bus.halted     = (state_q == S_HALT) & ~rst;
   assign bus.halt_cause = rst ? 2'b00 : cause_q;
endmodule
